vdp_cpu_port: RTL and testbench
===============================

# vdp_cpu_port

CPU-side write/read port of the VDP: decodes Z80 accesses to the data port (0xBE) and control port (0xBF) into VRAM writes, VRAM prefetch reads, CRAM writes, VDP register writes and status reads. It owns the 14-bit address register, the 2-bit code register, the one-byte read buffer and the 10-entry register file consumed by the display pipeline. VRAM accesses are issued only while the display interface deasserts `screenBusy`; CPU accesses stall via `cpu_wait` until the pending VRAM operation retires.

## Interface
- Parameters: none; sizes come from `vdp_pkg`.
- `clk` in 1: 25 MHz clock.
- `rst_L` in 1: asynchronous, active-low reset.
- `cpu_wr` in 1: CPU write strobe, held until accepted.
- `cpu_rd` in 1: CPU read strobe, held until accepted.
- `cpu_port` in 1: 0 = data port, 1 = control port.
- `cpu_din` in 8: CPU write data.
- `cpu_dout` out 8: read data, valid in the accept cycle.
- `cpu_wait` out 1: 1 = access not accepted this cycle.
- `screenBusy` in 1: display owns VRAM when 1.
- `vram_addr` out 14: VRAM address for the CPU-side access.
- `vram_wdata` out 8: VRAM write data.
- `vram_we` out 1: one-cycle VRAM write.
- `vram_re` out 1: one-cycle VRAM read.
- `vram_rdata` in 8: valid 2 cycles after `vram_re`.
- `cram_addr` out 5: CRAM write address.
- `cram_wdata` out 6: CRAM write data (`cpu_din[5:0]`).
- `cram_we` out 1: one-cycle CRAM write.
- `vint_set`, `spr_ovf_set`, `spr_coll_set` in 1 each: status flag set pulses.
- `regFile` out 10x8: VDP registers 0-9.
- `irq` out 1: `vint_flag & regFile[1][5]`.

## Operation
- A request is accepted in any cycle where `cpu_wr|cpu_rd` is high and `cpu_wait` is low. `cpu_wait = (state != IDLE)`.
- Control write, first byte (`first_done=0`): `addr[7:0] <= cpu_din`, `first_done <= 1`.
- Control write, second byte: `code <= cpu_din[7:6]`, `addr[13:8] <= cpu_din[5:0]`, `first_done <= 0`. Then by code:
  - 0: start a prefetch read at `addr`, then `addr++`.
  - 1: VRAM write mode; no access.
  - 2: `regFile[cpu_din[3:0]] <= addr[7:0]` if index < 10, otherwise ignored.
  - 3: CRAM write mode.
- Data write (clears `first_done`):
  - code 3: `cram_we=1` in the accept cycle with `cram_addr=addr[4:0]`; no stall.
  - Any other code: latch pending address and data, go to WR_PEND.
  - In both cases `read_buf <= cpu_din` and `addr++`.
- Data read: `cpu_dout = read_buf`, `first_done <= 0`, prefetch from `addr`, `addr++`.
- Control read: `cpu_dout = {vint_flag, ovf_flag, coll_flag, 5'b0}`. Clears all three flags and `first_done`.
- `addr` is 14 bits and wraps 0x3FFF to 0x0000.
- FSM states:
  - IDLE.
  - WR_PEND: when `!screenBusy`, assert `vram_we` and go to IDLE.
  - RD_PEND: when `!screenBusy`, assert `vram_re` and go to RD_W1.
  - RD_W1: go to RD_W2.
  - RD_W2: `read_buf <= vram_rdata`, go to IDLE.
- Status flags: a set pulse in the same cycle as a clearing status read leaves the flag at 1; the read returns the pre-set value.

## Timing
- Reset values:
  - All outputs 0.
  - `regFile` all 0.
  - `addr`, `code`, `read_buf`, `first_done`, and all flags 0.
  - State IDLE.
- Reset during WR_PEND or a read drops the operation; no `vram_we`/`vram_re` is issued after reset.
- Write latency: `vram_we` no earlier than 1 cycle after accept; unbounded while `screenBusy=1`.
- Read latency: `vram_re` no earlier than 1 cycle after accept; buffer updated 3 cycles after `vram_re`; `cpu_wait` drops the cycle after that.
- `vram_addr`/`vram_wdata` are registered and stable for the whole pending period.
- `regFile` update is visible the cycle after the accepting edge.

## Structure
- `vdp_pkg`: code enum (`VRAM_RD=0, VRAM_WR=1, REG_WR=2, CRAM_WR=3`), `NUM_VDP_REGS=10`, status bit positions, port select constants.
- Sub-module `vdp_cpu_port_fsm`: the IDLE/WR_PEND/RD_PEND/RD_W1/RD_W2 sequencer producing `vram_we`, `vram_re`, `buf_load` and `cpu_wait`.
- Datapath registers use the shared `register` module.

## Test plan
- Control 0x00, 0x81 → `regFile[1]=0x00`. Control 0x60, 0x81 → `regFile[1]=0x60`; `vint_set` then makes `irq=1`.
- Control 0xFF, 0x7F (addr 0x3FFF, VRAM write), data 0xAA, 0xBB → writes 0x3FFF=0xAA then 0x0000=0xBB (wrap).
- Hold `screenBusy=1` for 40 cycles during a data write → `vram_we` stays 0 and `cpu_wait` stays 1; `vram_we` fires 1 cycle after `screenBusy` falls.
- Preload VRAM 0x0100=0x12, 0x0101=0x34. Control 0x00, 0x01 → prefetch. Data read returns 0x12, next data read returns 0x34; `addr` ends at 0x0103.
- Control 0x05, 0xC0, data 0x3F → `cram_we` with `cram_addr=5`, `cram_wdata=0x3F`, no stall.
- Control write of 0x34, then control read → status returned, `first_done` cleared. Next control 0x00, 0x40 sets `addr=0x0000`. `vint_set` coincident with a status read → flag still 1 afterwards.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU-side port.
package vdp_pkg;

  localparam int unsigned NUM_VDP_REGS = 10;
  localparam int unsigned ADDR_W       = 14;

  localparam int unsigned STAT_VINT = 7;
  localparam int unsigned STAT_OVF  = 6;
  localparam int unsigned STAT_COLL = 5;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  typedef enum logic [1:0] {
    VRAM_RD = 2'd0,
    VRAM_WR = 2'd1,
    REG_WR  = 2'd2,
    CRAM_WR = 2'd3
  } vdpCode_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_PEND,
    RD_PEND,
    RD_W1,
    RD_W2
  } portState_t;

  // Flags packed as {vint, ovf, coll}.
  function automatic logic [7:0] statusByte(input logic [2:0] f);
    logic [7:0] s;
    s = '0;
    s[STAT_VINT] = f[2];
    s[STAT_OVF]  = f[1];
    s[STAT_COLL] = f[0];
    return s;
  endfunction

endpackage

// File: rtl/register.sv
// Shared enable register with asynchronous active-low clear.
module register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/vdp_cpu_port_fsm.sv
// VRAM access sequencer: holds CPU off while a write or prefetch read is in flight.
module vdp_cpu_port_fsm
  import vdp_pkg::*;
(
  input  logic clk,
  input  logic rst_L,
  input  logic startWr,
  input  logic startRd,
  input  logic screenBusy,
  output logic vram_we,
  output logic vram_re,
  output logic buf_load,
  output logic cpu_wait
);

  portState_t state;

  // cpu_wait stays high through the buf_load cycle so a read never sees a stale buffer.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state    <= IDLE;
      vram_we  <= 1'b0;
      vram_re  <= 1'b0;
      buf_load <= 1'b0;
      cpu_wait <= 1'b0;
    end else begin
      vram_we  <= 1'b0;
      vram_re  <= 1'b0;
      buf_load <= 1'b0;
      case (state)
        IDLE: begin
          if (startWr) begin
            state    <= WR_PEND;
            cpu_wait <= 1'b1;
          end else if (startRd) begin
            state    <= RD_PEND;
            cpu_wait <= 1'b1;
          end else begin
            cpu_wait <= 1'b0;
          end
        end
        WR_PEND: begin
          if (!screenBusy) begin
            vram_we  <= 1'b1;
            state    <= IDLE;
            cpu_wait <= 1'b0;
          end
        end
        RD_PEND: begin
          if (!screenBusy) begin
            vram_re <= 1'b1;
            state   <= RD_W1;
          end
        end
        RD_W1: state <= RD_W2;
        RD_W2: begin
          buf_load <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          cpu_wait <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/vdp_cpu_port.sv
// Z80-facing VDP port: address/code registers, read buffer, status flags and register file.
module vdp_cpu_port
  import vdp_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_L,
  input  logic                           cpu_wr,
  input  logic                           cpu_rd,
  input  logic                           cpu_port,
  input  logic [7:0]                     cpu_din,
  output logic [7:0]                     cpu_dout,
  output logic                           cpu_wait,
  input  logic                           screenBusy,
  output logic [ADDR_W-1:0]              vram_addr,
  output logic [7:0]                     vram_wdata,
  output logic                           vram_we,
  output logic                           vram_re,
  input  logic [7:0]                     vram_rdata,
  output logic [4:0]                     cram_addr,
  output logic [5:0]                     cram_wdata,
  output logic                           cram_we,
  input  logic                           vint_set,
  input  logic                           spr_ovf_set,
  input  logic                           spr_coll_set,
  output logic [NUM_VDP_REGS-1:0][7:0]   regFile,
  output logic                           irq
);

  logic [ADDR_W-1:0] addr, addrD, newAddr, vramAddrD;
  logic [1:0]        code;
  logic              firstDone;
  logic [7:0]        readBuf, readBufD;
  logic [2:0]        flags, flagsD;
  logic              wrAcc, rdAcc, ctrlWr, ctrlWr1, ctrlWr2, dataWr, ctrlRd, dataRd;
  logic              startWr, startRd, bufLoad, regWr, addrEn, readBufEn;
  vdpCode_t          newCode, curCode;

  assign wrAcc   = cpu_wr & ~cpu_wait;
  assign rdAcc   = cpu_rd & ~cpu_wr & ~cpu_wait;
  assign ctrlWr  = wrAcc & (cpu_port == PORT_CTRL);
  assign dataWr  = wrAcc & (cpu_port == PORT_DATA);
  assign ctrlRd  = rdAcc & (cpu_port == PORT_CTRL);
  assign dataRd  = rdAcc & (cpu_port == PORT_DATA);
  assign ctrlWr1 = ctrlWr & ~firstDone;
  assign ctrlWr2 = ctrlWr & firstDone;

  assign newAddr = {cpu_din[5:0], addr[7:0]};
  assign newCode = vdpCode_t'(cpu_din[7:6]);
  assign curCode = vdpCode_t'(code);

  assign startRd = (ctrlWr2 & (newCode == VRAM_RD)) | dataRd;
  assign startWr = dataWr & (curCode != CRAM_WR);
  assign regWr   = ctrlWr2 & (newCode == REG_WR) & (cpu_din[3:0] < 4'(NUM_VDP_REGS));
  assign addrEn  = ctrlWr | dataWr | dataRd;
  assign readBufEn = dataWr | bufLoad;

  always_comb begin
    addrD     = addr + 14'd1;
    vramAddrD = addr;
    readBufD  = bufLoad ? vram_rdata : cpu_din;
    if (ctrlWr1) begin
      addrD = {addr[13:8], cpu_din};
    end else if (ctrlWr2) begin
      vramAddrD = newAddr;
      addrD     = (newCode == VRAM_RD) ? newAddr + 14'd1 : newAddr;
    end
  end

  // A set pulse wins over a clearing status read in the same cycle.
  assign flagsD = {vint_set, spr_ovf_set, spr_coll_set} | (flags & ~{3{ctrlRd}});

  register #(.WIDTH(ADDR_W)) uAddr (
    .clk(clk), .rst_L(rst_L), .en(addrEn), .d(addrD), .q(addr));
  register #(.WIDTH(2)) uCode (
    .clk(clk), .rst_L(rst_L), .en(ctrlWr2), .d(cpu_din[7:6]), .q(code));
  register #(.WIDTH(1)) uFirst (
    .clk(clk), .rst_L(rst_L), .en(wrAcc | rdAcc), .d(ctrlWr1), .q(firstDone));
  register #(.WIDTH(8)) uReadBuf (
    .clk(clk), .rst_L(rst_L), .en(readBufEn), .d(readBufD), .q(readBuf));
  register #(.WIDTH(3)) uFlags (
    .clk(clk), .rst_L(rst_L), .en(1'b1), .d(flagsD), .q(flags));
  register #(.WIDTH(ADDR_W)) uVramAddr (
    .clk(clk), .rst_L(rst_L), .en(startWr | startRd), .d(vramAddrD), .q(vram_addr));
  register #(.WIDTH(8)) uVramWdata (
    .clk(clk), .rst_L(rst_L), .en(startWr), .d(cpu_din), .q(vram_wdata));

  for (genvar i = 0; i < NUM_VDP_REGS; i++) begin : gRegs
    register #(.WIDTH(8)) uReg (
      .clk(clk), .rst_L(rst_L), .en(regWr && (cpu_din[3:0] == 4'(i))),
      .d(addr[7:0]), .q(regFile[i]));
  end

  vdp_cpu_port_fsm uFsm (
    .clk(clk), .rst_L(rst_L), .startWr(startWr), .startRd(startRd),
    .screenBusy(screenBusy), .vram_we(vram_we), .vram_re(vram_re),
    .buf_load(bufLoad), .cpu_wait(cpu_wait));

  assign cpu_dout   = (cpu_port == PORT_CTRL) ? statusByte(flags) : readBuf;
  assign cram_we    = dataWr & (curCode == CRAM_WR);
  assign cram_addr  = addr[4:0];
  assign cram_wdata = cpu_din[5:0];
  assign irq        = flags[2] & regFile[1][5];

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a small VRAM model behind the port.
module tb_vdp_cpu_port;

  logic            clk = 1'b0;
  logic            rst_L = 1'b0;
  logic            cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_port = 1'b0;
  logic [7:0]      cpu_din = '0;
  logic [7:0]      cpu_dout;
  logic            cpu_wait;
  logic            screenBusy = 1'b0;
  logic [13:0]     vram_addr;
  logic [7:0]      vram_wdata;
  logic            vram_we, vram_re;
  logic [7:0]      vram_rdata = '0;
  logic [4:0]      cram_addr;
  logic [5:0]      cram_wdata;
  logic            cram_we;
  logic            vint_set = 1'b0, spr_ovf_set = 1'b0, spr_coll_set = 1'b0;
  logic [9:0][7:0] regFile;
  logic            irq;

  int checks = 0;
  int failures = 0;

  vdp_cpu_port dut (
    .clk(clk), .rst_L(rst_L), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_port(cpu_port),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait), .screenBusy(screenBusy),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re),
    .vram_rdata(vram_rdata), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
    .cram_we(cram_we), .vint_set(vint_set), .spr_ovf_set(spr_ovf_set),
    .spr_coll_set(spr_coll_set), .regFile(regFile), .irq(irq));

  always #20 clk = ~clk;

  // VRAM model: read data appears two cycles after vram_re.
  logic [7:0] mem [16384];
  logic [7:0] rdPipe = '0;
  int weCount = 0;
  int reCount = 0;

  always @(posedge clk) begin
    if (vram_we) begin
      mem[vram_addr] = vram_wdata;
      weCount = weCount + 1;
    end
    if (vram_re) reCount = reCount + 1;
    rdPipe     <= vram_re ? mem[vram_addr] : 8'h00;
    vram_rdata <= rdPipe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpuAccess(input logic isWr, input logic port, input logic [7:0] din,
                           output logic [7:0] dout, output int waits);
    bit done = 1'b0;
    waits = 0;
    dout = '0;
    cpu_wr = isWr;
    cpu_rd = !isWr;
    cpu_port = port;
    cpu_din = din;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!cpu_wait) begin
        dout = cpu_dout;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: got cpu_wait=1 for 200 cycles expected accept");
    end
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulseFlags(input logic v, input logic o, input logic c);
    vint_set = v; spr_ovf_set = o; spr_coll_set = c;
    @(posedge clk); #1;
    vint_set = 1'b0; spr_ovf_set = 1'b0; spr_coll_set = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int unsigned idx;
    logic [7:0]  exp;
  } regVec_t;

  regVec_t vecs[7];
  logic [7:0] d;
  int w;
  int bad;
  int weSnap;

  initial begin
    vecs[0] = '{"reg1_00",      8'h00, 8'h81, 1, 8'h00};
    vecs[1] = '{"reg1_60",      8'h60, 8'h81, 1, 8'h60};
    vecs[2] = '{"reg0_12",      8'h12, 8'h80, 0, 8'h12};
    vecs[3] = '{"reg9_A5",      8'hA5, 8'h89, 9, 8'hA5};
    vecs[4] = '{"idx10_ignore", 8'h77, 8'h8A, 9, 8'hA5};
    vecs[5] = '{"reg5_3C",      8'h3C, 8'h85, 5, 8'h3C};
    vecs[6] = '{"idx15_ignore", 8'hFF, 8'h8F, 5, 8'h3C};

    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;

    // Reset state
    idle(3);
    @(negedge clk);
    check("rst_cpu_wait", cpu_wait, 0);
    check("rst_vram_we", vram_we, 0);
    check("rst_vram_re", vram_re, 0);
    check("rst_cram_we", cram_we, 0);
    check("rst_irq", irq, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_vram_addr", vram_addr, 0);
    check("rst_regfile", {31'd0, |regFile}, 0);
    @(posedge clk); #1;
    rst_L = 1'b1;
    idle(2);

    // Register writes from the table
    for (int i = 0; i < 7; i++) begin
      cpuAccess(1'b1, 1'b1, vecs[i].b0, d, w);
      cpuAccess(1'b1, 1'b1, vecs[i].b1, d, w);
      check(vecs[i].name, regFile[vecs[i].idx], vecs[i].exp);
    end
    check("reg1_keep", regFile[1], 8'h60);

    // Vertical interrupt with reg1 bit5 set
    pulseFlags(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("irq_set", irq, 1);
    @(posedge clk); #1;
    cpuAccess(1'b0, 1'b1, 8'h00, d, w);
    check("status_vint", d, 8'h80);
    @(negedge clk);
    check("irq_cleared", irq, 0);
    @(posedge clk); #1;

    // Address wrap on VRAM writes
    cpuAccess(1'b1, 1'b1, 8'hFF, d, w);
    cpuAccess(1'b1, 1'b1, 8'h7F, d, w);
    weSnap = weCount;
    cpuAccess(1'b1, 1'b0, 8'hAA, d, w);
    cpuAccess(1'b1, 1'b0, 8'hBB, d, w);
    idle(3);
    check("wrap_mem3FFF", mem[14'h3FFF], 8'hAA);
    check("wrap_mem0000", mem[14'h0000], 8'hBB);
    check("wrap_we_count", weCount - weSnap, 2);

    // Write held off by screenBusy
    cpuAccess(1'b1, 1'b1, 8'h00, d, w);
    cpuAccess(1'b1, 1'b1, 8'h42, d, w);
    screenBusy = 1'b1;
    cpuAccess(1'b1, 1'b0, 8'h5A, d, w);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vram_we !== 1'b0 || cpu_wait !== 1'b1) bad++;
    end
    check("busy_hold_violations", bad, 0);
    @(posedge clk); #1;
    screenBusy = 1'b0;
    @(negedge clk);
    check("busy_we_not_early", vram_we, 0);
    @(negedge clk);
    check("busy_we_fire", vram_we, 1);
    check("busy_addr", vram_addr, 14'h0200);
    check("busy_wdata", vram_wdata, 8'h5A);
    check("busy_wait_drop", cpu_wait, 0);
    @(negedge clk);
    check("busy_we_one_cycle", vram_we, 0);
    @(posedge clk); #1;

    // Prefetch reads
    mem[14'h0100] = 8'h12;
    mem[14'h0101] = 8'h34;
    cpuAccess(1'b1, 1'b1, 8'h00, d, w);
    cpuAccess(1'b1, 1'b1, 8'h01, d, w);
    cpuAccess(1'b0, 1'b0, 8'h00, d, w);
    check("read_first", d, 8'h12);
    cpuAccess(1'b0, 1'b0, 8'h00, d, w);
    check("read_second", d, 8'h34);
    check("read_wait_cycles", w, 4);
    cpuAccess(1'b1, 1'b0, 8'hC3, d, w);
    idle(3);
    check("read_addr_end", mem[14'h0103], 8'hC3);

    // CRAM writes, no stall
    cpuAccess(1'b1, 1'b1, 8'h05, d, w);
    cpuAccess(1'b1, 1'b1, 8'hC0, d, w);
    cpu_wr = 1'b1; cpu_port = 1'b0; cpu_din = 8'h3F;
    @(negedge clk);
    check("cram_no_wait", cpu_wait, 0);
    check("cram_we", cram_we, 1);
    check("cram_addr", cram_addr, 5);
    check("cram_wdata", cram_wdata, 6'h3F);
    @(posedge clk); #1;
    cpu_din = 8'h15;
    @(negedge clk);
    check("cram2_no_wait", cpu_wait, 0);
    check("cram2_addr", cram_addr, 6);
    check("cram2_wdata", cram_wdata, 6'h15);
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    @(negedge clk);
    check("cram_we_drop", cram_we, 0);
    @(posedge clk); #1;

    // Status read clears the first-byte latch
    pulseFlags(1'b0, 1'b1, 1'b1);
    mem[14'h0000] = 8'h00;
    cpuAccess(1'b1, 1'b1, 8'h34, d, w);
    cpuAccess(1'b0, 1'b1, 8'h00, d, w);
    check("status_ovf_coll", d, 8'h60);
    cpuAccess(1'b1, 1'b1, 8'h00, d, w);
    cpuAccess(1'b1, 1'b1, 8'h40, d, w);
    cpuAccess(1'b1, 1'b0, 8'h99, d, w);
    idle(3);
    check("firstdone_cleared", mem[14'h0000], 8'h99);

    // Set pulse coincident with a clearing status read
    cpu_rd = 1'b1; cpu_port = 1'b1; vint_set = 1'b1;
    @(negedge clk);
    check("coincide_read", cpu_dout, 8'h00);
    @(posedge clk); #1;
    cpu_rd = 1'b0; vint_set = 1'b0;
    @(negedge clk);
    check("coincide_irq", irq, 1);
    @(posedge clk); #1;
    cpuAccess(1'b0, 1'b1, 8'h00, d, w);
    check("coincide_flag_kept", d, 8'h80);

    // Reset while a write is pending
    cpuAccess(1'b1, 1'b1, 8'h00, d, w);
    cpuAccess(1'b1, 1'b1, 8'h43, d, w);
    screenBusy = 1'b1;
    cpuAccess(1'b1, 1'b0, 8'h11, d, w);
    weSnap = weCount;
    rst_L = 1'b0;
    @(negedge clk);
    check("rst_mid_wait", cpu_wait, 0);
    @(posedge clk); #1;
    rst_L = 1'b1;
    screenBusy = 1'b0;
    idle(5);
    check("rst_drop_we", weCount - weSnap, 0);
    check("rst_drop_mem", mem[14'h0300], 8'h00);
    check("rst_regfile1", regFile[1], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
